// File: rtl/spi_reg_responder.sv
// SPI mode-0 register slave: 32-bit LSB-first frames {data[27:0], addr[3:0]} write a
// small register bank, address 4'hE arms a readback returned on the next frame's MISO.
`timescale 1ns/1ps
module spi_reg_responder #(
   parameter int NUM_REGS    = 9,
   parameter int SYNC_STAGES = 2
) (
   input  logic        BOARD_CLOCK,
   input  logic        RST,
   input  logic        SPI_SCLK,
   input  logic        SPI_CS_N,
   input  logic        SPI_MOSI,
   output logic        SPI_MISO,
   output logic        SPI_MISO_OE,
   output logic        WR_STB,
   output logic [3:0]  WR_ADDR,
   output logic [27:0] WR_DATA,
   input  logic [3:0]  REG_ADDR,
   output logic [27:0] REG_RDATA,
   output logic        FRAME_ERR
);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   localparam logic [4:0] NREG = 5'(NUM_REGS);

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, vld_sync;
   logic sclk_s, cs_s, mosi_s, vld_s;
   logic sclk_d, cs_d, armed;
   logic sclk_rise, sclk_fall, cs_fall;

   logic [5:0]  bit_cnt;
   logic [31:0] shift_in, shift_out;
   logic [3:0]  rd_addr;
   logic        rd_pend;
   logic [27:0] regs [16];
   logic [27:0] rd_word;

   logic        frame_full, wr_hit;
   logic [3:0]  frame_addr;
   logic [27:0] frame_data;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign vld_s  = vld_sync[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   // A frame may only start once a genuine (post-reset) high level of CS_N has been seen.
   assign cs_fall   = armed & cs_d & ~cs_s;

   assign frame_full = (bit_cnt == 6'd32);
   assign frame_addr = shift_in[3:0];
   assign frame_data = shift_in[31:4];
   assign wr_hit     = ({1'b0, frame_addr} < NREG);
   assign rd_word    = ({1'b0, rd_addr} < NREG) ? regs[rd_addr] : '0;

   always_ff @(posedge BOARD_CLOCK or posedge RST) begin
      if (RST) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         vld_sync  <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
         armed     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS_N};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
         vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
         if (vld_s && cs_s)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge BOARD_CLOCK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cs_fall) state_next = SHIFT;
         SHIFT:   if (cs_s)    state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      SPI_MISO_OE = (state == SHIFT);
      SPI_MISO    = (state == SHIFT) & shift_out[0];
      WR_STB      = 1'b0;
      WR_ADDR     = '0;
      WR_DATA     = '0;
      FRAME_ERR   = 1'b0;
      if (state == COMMIT) begin
         if (!frame_full) begin
            FRAME_ERR = 1'b1;
         end else if (wr_hit) begin
            WR_STB  = 1'b1;
            WR_ADDR = frame_addr;
            WR_DATA = frame_data;
         end
      end
   end

   always_ff @(posedge BOARD_CLOCK or posedge RST) begin
      if (RST) begin
         bit_cnt   <= '0;
         shift_in  <= '0;
         shift_out <= '0;
         rd_addr   <= '0;
         rd_pend   <= 1'b0;
         REG_RDATA <= '0;
         for (int i = 0; i < 16; i++)
            regs[i] <= '0;
      end else begin
         REG_RDATA <= ({1'b0, REG_ADDR} < NREG) ? regs[REG_ADDR] : '0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  bit_cnt   <= '0;
                  shift_in  <= '0;
                  shift_out <= rd_pend ? {rd_word, rd_addr} : '0;
                  rd_pend   <= 1'b0;
               end
            end
            SHIFT: begin
               // Edges coinciding with the detected CS_N rise belong to no frame.
               if (!cs_s) begin
                  if (sclk_rise && bit_cnt != 6'd33) begin
                     if (bit_cnt < 6'd32)
                        shift_in[bit_cnt[4:0]] <= mosi_s;
                     bit_cnt <= bit_cnt + 6'd1;
                  end
                  if (sclk_fall)
                     shift_out <= {1'b0, shift_out[31:1]};
               end
            end
            COMMIT: begin
               if (frame_full) begin
                  if (wr_hit) begin
                     regs[frame_addr] <= frame_data;
                  end else if (frame_addr == 4'hE) begin
                     rd_addr <= shift_in[7:4];
                     rd_pend <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
